mdu_iter: RTL and testbench

//  Parametrised iterative multiply/divide unit for the EX stage: executes all RV M-extension ops
//  (mul/mulh/mulhsu/mulhu/div/divu/rem/remu) plus RV64 *W forms. Uses one shift-add multiplier and
//  one restoring divider behind a single valid/ready request/response pair. Adds 1-cycle handling
//  of div-by-zero/overflow and a quotient/remainder cache for back-to-back div+rem on equal operands.

---
 rtl/mdu_iter.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mdu_iter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the RV M extension (plus RV64 W forms).
// One shift-add multiplier and one restoring divider share a single
// request/response pair. Divide-by-zero, signed overflow and repeated
// div/rem on identical operands complete one cycle after the setup cycle.
//
// Handshake: a request is taken on a rising edge where in_valid and in_ready
// are both 1 and flush is 0; a result is handed over on a rising edge where
// out_valid and out_ready are both 1. in_ready is 1 only in IDLE, out_valid
// only in DONE, and result is held stable for as long as out_valid is 1.
module mdu_iter #(
  parameter int XLEN     = 64,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            op_w,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] LO32  = XLEN'(32'hFFFF_FFFF);
  localparam logic [XLEN-1:0] HI32  = ~LO32;
  localparam logic [XLEN-1:0] MIN_W = HI32 | XLEN'(32'h8000_0000);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Sign-extend bit 31 over the upper half for word results.
  function automatic logic [XLEN-1:0] fmt_w(input logic [XLEN-1:0] v, input logic w);
    fmt_w = w ? ((v & LO32) | ({XLEN{v[31]}} & HI32)) : v;
  endfunction

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_op;
  logic                r_w;
  logic [XLEN-1:0]     r_src1;
  logic [XLEN-1:0]     r_src2;
  logic                r_first;
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [2*XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]     r_mplier;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_mag_b;
  logic                r_neg_a;
  logic                r_neg_b;
  logic [XLEN-1:0]     r_result;
  logic                r_c_valid;
  logic [XLEN-1:0]     r_c_src1;
  logic [XLEN-1:0]     r_c_src2;
  logic                r_c_signed;
  logic                r_c_w;
  logic [XLEN-1:0]     r_c_quo;
  logic [XLEN-1:0]     r_c_rem;

  logic                w_accept;
  logic                w_word_in;
  logic                w_signed_a;
  logic                w_signed_b;
  logic                w_is_rem;
  logic [XLEN-1:0]     w_ext_a;
  logic [XLEN-1:0]     w_ext_b;
  logic                w_neg_a;
  logic                w_neg_b;
  logic [XLEN-1:0]     w_mag_a;
  logic [XLEN-1:0]     w_mag_b;
  logic                w_dbz;
  logic                w_ovf;
  logic                w_hit;
  logic                w_last;
  logic [2*XLEN-1:0]   w_acc_step;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_mul_res;
  logic [XLEN:0]       w_shift;
  logic [XLEN:0]       w_trial;
  logic                w_qbit;
  logic [XLEN-1:0]     w_rem_step;
  logic [XLEN-1:0]     w_quo_step;
  logic [XLEN-1:0]     w_q_fix;
  logic [XLEN-1:0]     w_r_fix;
  logic [XLEN-1:0]     w_div_res;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign dbg_state = r_state;

  assign w_accept  = in_valid && in_ready && !flush;
  // mulh/mulhsu/mulhu have no word form; op_w is meaningless at XLEN=32.
  assign w_word_in = (XLEN == 64) && op_w && !(!op[2] && (op[1:0] != 2'b00));

  // Operand decode on the latched request copy.
  assign w_signed_a = (r_op == 3'b001) || (r_op == 3'b010) || (r_op[2] && !r_op[0]);
  assign w_signed_b = (r_op == 3'b001) || (r_op[2] && !r_op[0]);
  assign w_is_rem   = r_op[1];
  assign w_ext_a    = r_w ? ((r_src1 & LO32) | ((w_signed_a && r_src1[31]) ? HI32 : '0)) : r_src1;
  assign w_ext_b    = r_w ? ((r_src2 & LO32) | ((w_signed_b && r_src2[31]) ? HI32 : '0)) : r_src2;
  assign w_neg_a    = w_signed_a && w_ext_a[XLEN-1];
  assign w_neg_b    = w_signed_b && w_ext_b[XLEN-1];
  assign w_mag_a    = w_neg_a ? -w_ext_a : w_ext_a;
  assign w_mag_b    = w_neg_b ? -w_ext_b : w_ext_b;

  // Divide shortcuts: zero divisor, MIN / -1, and a repeat of the cached pair.
  assign w_dbz = (w_ext_b == '0);
  assign w_ovf = w_signed_a && (w_ext_a == (r_w ? MIN_W : MIN_X)) && (&w_ext_b);
  assign w_hit = CACHE_EN && r_c_valid && (r_c_src1 == r_src1) && (r_c_src2 == r_src2) &&
                 (r_c_signed == w_signed_a) && (r_c_w == r_w);

  assign w_last = r_w ? (r_cnt == CW'(31)) : (r_cnt == CW'(XLEN - 1));

  // Multiply step and sign fix-up of the full 2*XLEN product.
  assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_prod     = (r_neg_a ^ r_neg_b) ? -w_acc_step : w_acc_step;
  assign w_mul_res  = (r_op == 3'b000) ? fmt_w(w_prod[XLEN-1:0], r_w) : w_prod[2*XLEN-1:XLEN];

  // Restoring divide step: remainder stays below the divisor, so the
  // top bit of the trial difference is a clean borrow.
  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_trial    = w_shift - {1'b0, r_mag_b};
  assign w_qbit     = !w_trial[XLEN];
  assign w_rem_step = w_qbit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_step = {r_quo[XLEN-2:0], w_qbit};
  assign w_q_fix    = (r_neg_a ^ r_neg_b) ? -w_quo_step : w_quo_step;
  assign w_r_fix    = r_neg_a ? -w_rem_step : w_rem_step;
  assign w_div_res  = w_is_rem ? fmt_w(w_r_fix, r_w) : fmt_w(w_q_fix, r_w);

  // Next-state decode; flush forces IDLE regardless of anything else.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = op[2] ? S_DIV : S_MUL;
      S_MUL:  if (!r_first && w_last) w_next = S_DONE;
      S_DIV: begin
        if (r_first) begin
          if (w_dbz || w_ovf || w_hit) w_next = S_DONE;
        end else if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Request capture, setup cycle, iterations, result and cache update.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op       <= '0;
      r_w        <= 1'b0;
      r_src1     <= '0;
      r_src2     <= '0;
      r_first    <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_mag_b    <= '0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_result   <= '0;
      r_c_valid  <= 1'b0;
      r_c_src1   <= '0;
      r_c_src2   <= '0;
      r_c_signed <= 1'b0;
      r_c_w      <= 1'b0;
      r_c_quo    <= '0;
      r_c_rem    <= '0;
    end else if (flush) begin
      r_first <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= op;
            r_w     <= w_word_in;
            r_src1  <= src1;
            r_src2  <= src2;
            r_first <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_MUL: begin
          if (r_first) begin
            r_first  <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_neg_a  <= w_neg_a;
            r_neg_b  <= w_neg_b;
          end else begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
              r_result <= w_mul_res;
              r_cnt    <= '0;
            end
          end
        end
        S_DIV: begin
          if (r_first) begin
            r_first <= 1'b0;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_mag_b <= w_mag_b;
            r_rem   <= '0;
            // Word dividends are left-aligned so N shifts consume exactly their bits.
            r_quo   <= r_w ? (w_mag_a << (XLEN - 32)) : w_mag_a;
            if (w_dbz)      r_result <= w_is_rem ? fmt_w(w_ext_a, r_w) : '1;
            else if (w_ovf) r_result <= w_is_rem ? '0 : w_ext_a;
            else if (w_hit) r_result <= w_is_rem ? r_c_rem : r_c_quo;
          end else begin
            r_rem <= w_rem_step;
            r_quo <= w_quo_step;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_result <= w_div_res;
              r_cnt    <= '0;
              if (CACHE_EN) begin
                r_c_valid  <= 1'b1;
                r_c_src1   <= r_src1;
                r_c_src2   <= r_src2;
                r_c_signed <= w_signed_a;
                r_c_w      <= r_w;
                r_c_quo    <= fmt_w(w_q_fix, r_w);
                r_c_rem    <= fmt_w(w_r_fix, r_w);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter (XLEN=64, cache enabled): directed vectors, randomized
// ops against an arithmetic reference model, backpressure, flush and reset.
module tb_mdu_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic        op_w = 1'b0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference cache image: last completed iterative div/rem key.
  logic        m_c_valid = 1'b0;
  logic [63:0] m_c_a, m_c_b;
  logic        m_c_s, m_c_w;

  mdu_iter #(.XLEN(64), .CACHE_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op_w(op_w), .src1(src1), .src2(src2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference result from plain wide arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  q, rm;
    logic [31:0]  q32, rm32;
    int           sa32, sb32;
    longint       sa, sb;
    logic         word, sgn;
    word = w && (o == 3'd0 || o[2]);
    sgn  = !o[0];
    p = '0; q = '0; rm = '0; q32 = '0; rm32 = '0;
    sa32 = a[31:0]; sb32 = b[31:0]; sa = a; sb = b;
    if (!o[2]) begin
      case (o)
        3'd0: p = {64'd0, a} * {64'd0, b};
        3'd1: p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
        3'd2: p = {{64{a[63]}}, a} * {64'd0, b};
        default: p = {64'd0, a} * {64'd0, b};
      endcase
      if (o == 3'd0) return word ? sx32(p[31:0]) : p[63:0];
      return p[127:64];
    end
    if (word) begin
      if (b[31:0] == 32'd0) begin q32 = '1; rm32 = a[31:0]; end
      else if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
        q32 = 32'h8000_0000; rm32 = '0;
      end else if (sgn) begin q32 = sa32 / sb32; rm32 = sa32 % sb32; end
      else begin q32 = a[31:0] / b[31:0]; rm32 = a[31:0] % b[31:0]; end
      return sx32(o[1] ? rm32 : q32);
    end
    if (b == 64'd0) begin q = '1; rm = a; end
    else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; rm = '0; end
    else if (sgn) begin q = sa / sb; rm = sa % sb; end
    else begin q = a / b; rm = a % b; end
    return o[1] ? rm : q;
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
    if (w) return (b[31:0] == 0) ||
                  (!o[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 0) || (!o[0] && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  function automatic bit cache_hits(input logic [2:0] o, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
    return m_c_valid && m_c_a == a && m_c_b == b && m_c_s == !o[0] && m_c_w == w;
  endfunction

  // Edges from accept to out_valid.
  function automatic int exp_lat(input logic [2:0] o, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    if (!o[2]) return (o == 3'd0 && w) ? 33 : 65;
    if (is_special(o, w, a, b) || cache_hits(o, w, a, b)) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic void cache_note(input logic [2:0] o, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
    if (o[2] && !is_special(o, w, a, b)) begin
      m_c_valid = 1'b1; m_c_a = a; m_c_b = b; m_c_s = !o[0]; m_c_w = w;
    end
  endfunction

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return {$urandom, 32'h8000_0000};
      4: return $urandom_range(0, 1) ? 64'($urandom_range(1, 40)) : -64'($urandom_range(1, 40));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one request, wait for its result, consume it (out_ready assumed 1).
  task automatic do_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, output int lat, output logic [63:0] res,
                       output logic rdy_after, output logic idle_after);
    @(negedge clock);
    in_valid = 1'b1; op = o; op_w = w; src1 = a; src2 = b;
    @(posedge clock);
    #1;
    in_valid = 1'b0; op = 3'($urandom); op_w = 1'($urandom);
    src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
    rdy_after = in_ready;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin lat = k; break; end
    end
    res = result;
    idle_after = 1'b0;
    if (lat > 0) begin
      @(posedge clock);
      #1;
      idle_after = in_ready && !out_valid;
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    m_c_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (result !== 64'd0) begin n_errors++; $display("FAIL reset_result got %h want 0", result); end
  endtask

  task automatic test_directed();
    logic [2:0]  to[10] = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd6};
    logic        tw[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [63:0] ta[10] = '{64'd3, '1, '1, 64'h8000_0000, 64'h8000_0000, 64'd100, 64'd100,
                            -64'd7, -64'd7, -64'd7};
    logic [63:0] tb[10] = '{-64'd5, 64'd2, 64'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0, 64'd0,
                            64'd2, 64'd2, 64'd3};
    logic [63:0] te[10] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'd1, '1, 64'hFFFF_FFFF_8000_0000, 64'd0,
                            '1, 64'd100, -64'd3, -64'd1, -64'd1};
    int          tl[10] = '{65, 65, 65, 1, 1, 1, 1, 65, 1, 65};
    int lat;
    logic [63:0] res;
    logic rdy, idle;
    for (int i = 0; i < 10; i++) begin
      do_op(to[i], tw[i], ta[i], tb[i], lat, res, rdy, idle);
      cache_note(to[i], tw[i], ta[i], tb[i]);
      n_checks++;
      if (res !== te[i]) begin n_errors++; $display("FAIL directed_%0d_result got %h want %h", i, res, te[i]); end
      n_checks++;
      if (lat !== tl[i]) begin n_errors++; $display("FAIL directed_%0d_latency got %0d want %0d", i, lat, tl[i]); end
      n_checks++;
      if (rdy !== 1'b0) begin n_errors++; $display("FAIL directed_%0d_in_ready_drop got %b want 0", i, rdy); end
      n_checks++;
      if (idle !== 1'b1) begin n_errors++; $display("FAIL directed_%0d_idle_after got %b want 1", i, idle); end
    end
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic w;
    logic [63:0] a = '0, b = '0, exp, res;
    int el, lat;
    logic rdy, idle;
    for (int i = 0; i < 40; i++) begin
      if (i > 0 && $urandom_range(0, 2) == 0) begin
        o = 3'($urandom_range(4, 7));
      end else begin
        o = 3'($urandom_range(0, 7));
        w = 1'($urandom_range(0, 1));
        a = rand_operand();
        b = rand_operand();
      end
      exp = ref_result(o, w, a, b);
      el  = exp_lat(o, w, a, b);
      do_op(o, w, a, b, lat, res, rdy, idle);
      cache_note(o, w, a, b);
      n_checks++;
      if (res !== exp) begin n_errors++; $display("FAIL random_%0d_result op=%0d w=%b got %h want %h", i, o, w, res, exp); end
      n_checks++;
      if (lat !== el) begin n_errors++; $display("FAIL random_%0d_latency op=%0d got %0d want %0d", i, o, lat, el); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] od[3];
    logic [63:0] a, b, exp, res;
    logic w;
    int el, lat;
    logic rdy, idle;
    for (int i = 0; i < 5; i++) begin
      a = {$urandom, $urandom};
      b = {1'b0, 31'($urandom), $urandom} | 64'h0000_0003_0000_0003;
      w = 1'($urandom_range(0, 1));
      od[0] = $urandom_range(0, 1) ? 3'd4 : 3'd5;
      od[1] = 3'($urandom_range(0, 3));
      od[2] = (i == 4) ? (od[0] ^ 3'b011) : (od[0] | 3'b010);
      for (int k = 0; k < 3; k++) begin
        exp = ref_result(od[k], w, a, b);
        el  = exp_lat(od[k], w, a, b);
        do_op(od[k], w, a, b, lat, res, rdy, idle);
        cache_note(od[k], w, a, b);
        n_checks++;
        if (res !== exp) begin n_errors++; $display("FAIL b2b_%0d_%0d_result got %h want %h", i, k, res, exp); end
        n_checks++;
        if (lat !== el) begin n_errors++; $display("FAIL b2b_%0d_%0d_latency got %0d want %0d", i, k, lat, el); end
        n_checks++;
        if (idle !== 1'b1) begin n_errors++; $display("FAIL b2b_%0d_%0d_idle got %b want 1", i, k, idle); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b, exp;
    int lat;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    exp = ref_result(3'd1, 1'b0, a, b);
    @(negedge clock);
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd1; op_w = 1'b0; src1 = a; src2 = b;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin lat = k; break; end
    end
    n_checks++;
    if (lat !== 65) begin n_errors++; $display("FAIL bp_latency got %0d want 65", lat); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      in_valid = (c == 2); op = 3'd0; src1 = 64'd9; src2 = 64'd9;
      @(posedge clock);
      #1;
      n_checks++;
      if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_hold_valid_%0d got %b want 1", c, out_valid); end
      n_checks++;
      if (result !== exp) begin n_errors++; $display("FAIL bp_hold_result_%0d got %h want %h", c, result, exp); end
      n_checks++;
      if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready_%0d got %b want 0", c, in_ready); end
    end
    @(negedge clock);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    logic [63:0] res;
    int lat, seen;
    logic rdy, idle;
    // Prime the cache with a known pair.
    do_op(3'd4, 1'b0, 64'd1000, 64'd7, lat, res, rdy, idle);
    cache_note(3'd4, 1'b0, 64'd1000, 64'd7);
    n_checks++;
    if (res !== 64'd142) begin n_errors++; $display("FAIL flush_prime got %h want %h", res, 64'd142); end
    // Start a different divide and flush it at E0+10.
    @(negedge clock);
    in_valid = 1'b1; op = 3'd5; op_w = 1'b0; src1 = 64'd5555; src2 = 64'd11;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL flush_idle got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clock);
      #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_errors++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen); end
    // A request presented together with flush is not taken.
    @(negedge clock);
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; src1 = 64'd2; src2 = 64'd3;
    @(posedge clock);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL flush_blocks_accept got ready=%b want 1", in_ready); end
    seen = 0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clock);
      #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_errors++; $display("FAIL flush_accept_result got %0d valid cycles want 0", seen); end
    // The cache survived the flush.
    do_op(3'd6, 1'b0, 64'd1000, 64'd7, lat, res, rdy, idle);
    n_checks++;
    if (res !== 64'd6) begin n_errors++; $display("FAIL flush_cache_result got %h want %h", res, 64'd6); end
    n_checks++;
    if (lat !== 1) begin n_errors++; $display("FAIL flush_cache_latency got %0d want 1", lat); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int lat;
    logic rdy, idle;
    do_op(3'd4, 1'b0, -64'd900, 64'd13, lat, res, rdy, idle);
    cache_note(3'd4, 1'b0, -64'd900, 64'd13);
    n_checks++;
    if (res !== -64'd69) begin n_errors++; $display("FAIL rstmid_prime got %h want %h", res, -64'd69); end
    @(negedge clock);
    in_valid = 1'b1; op = 3'd0; op_w = 1'b0; src1 = 64'd77; src2 = 64'd88;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_c_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'd0) begin
      n_errors++;
      $display("FAIL rstmid_state got ready=%b valid=%b result=%h want 1 0 0", in_ready, out_valid, result);
    end
    do_op(3'd6, 1'b0, -64'd900, 64'd13, lat, res, rdy, idle);
    n_checks++;
    if (res !== -64'd3) begin n_errors++; $display("FAIL rstmid_rem got %h want %h", res, -64'd3); end
    n_checks++;
    if (lat !== exp_lat(3'd6, 1'b0, -64'd900, 64'd13)) begin
      n_errors++; $display("FAIL rstmid_cache_cleared latency got %0d want 65", lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
